// File: rtl/text_buffer.sv
// Character store for the text grid with a cursor-driven write port.
// Read: combinational (character_id is valid in the same cycle as char_row/char_col).
//   Write: one accepted character per cycle in IDLE.
// Backpressure: in_ready is low during the row and screen clearing sweeps.
module text_buffer #(
  parameter int              ROWS     = 15,
  parameter int              COLS     = 40,
  parameter int              ROW_W    = 4,
  parameter int              COL_W    = 6,
  parameter int              ID_W     = 8,
  parameter logic [ID_W-1:0] BLANK_ID = 8'h20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [ID_W-1:0]  in_char,
  output logic             in_ready,
  input  logic [ROW_W-1:0] char_row,
  input  logic [COL_W-1:0] char_col,
  output logic [ID_W-1:0]  character_id,
  output logic [ROW_W-1:0] cursor_row,
  output logic [COL_W-1:0] cursor_col,
  output logic             busy
);

  localparam int DEPTH  = ROWS * COLS;
  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ROW_END   = ADDR_W'(COLS - 1);

  localparam logic [ID_W-1:0] CH_BS = ID_W'(8'h08);
  localparam logic [ID_W-1:0] CH_NL = ID_W'(8'h0A);
  localparam logic [ID_W-1:0] CH_FF = ID_W'(8'h0C);

  typedef enum logic [1:0] {S_IDLE, S_CLR_ALL, S_CLR_ROW} state_t;

  state_t            r_state, w_state_nxt;
  logic [ROW_W-1:0]  r_row, w_row_nxt, w_row_inc;
  logic [COL_W-1:0]  r_col, w_col_nxt;
  logic [ADDR_W-1:0] r_sweep, w_sweep_nxt;
  logic              w_fire;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [ID_W-1:0]   w_wdata;
  logic [ADDR_W-1:0] w_rd_addr;

  logic [ID_W-1:0] r_mem [DEPTH];

  function automatic logic [ADDR_W-1:0] f_addr(input logic [ROW_W-1:0] r,
                                               input logic [COL_W-1:0] c);
    return ADDR_W'(int'(r) * COLS + int'(c));
  endfunction

  assign w_fire    = in_valid && (r_state == S_IDLE);
  assign w_row_inc = (r_row == LAST_ROW) ? '0 : r_row + 1'b1;

  // State register; reset restarts the full-screen sweep from address 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_CLR_ALL;
      r_row   <= '0;
      r_col   <= '0;
      r_sweep <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_sweep <= w_sweep_nxt;
    end
  end

  // Next state, cursor and sweep position
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_sweep_nxt = r_sweep;
    case (r_state)
      S_CLR_ALL: begin
        w_row_nxt = '0;
        w_col_nxt = '0;
        if (r_sweep == LAST_ADDR) w_state_nxt = S_IDLE;
        else                      w_sweep_nxt = r_sweep + 1'b1;
      end
      S_CLR_ROW: begin
        if (r_sweep == ROW_END) w_state_nxt = S_IDLE;
        else                    w_sweep_nxt = r_sweep + 1'b1;
      end
      default: begin
        if (w_fire) begin
          if (in_char == CH_NL) begin
            w_col_nxt   = '0;
            w_row_nxt   = w_row_inc;
            w_sweep_nxt = '0;
            w_state_nxt = S_CLR_ROW;
          end else if (in_char == CH_BS) begin
            if (r_col != '0) begin
              w_col_nxt = r_col - 1'b1;
            end else if (r_row != '0) begin
              w_row_nxt = r_row - 1'b1;
              w_col_nxt = LAST_COL;
            end
          end else if (in_char == CH_FF) begin
            w_row_nxt   = '0;
            w_col_nxt   = '0;
            w_sweep_nxt = '0;
            w_state_nxt = S_CLR_ALL;
          end else if (r_col != LAST_COL) begin
            w_col_nxt = r_col + 1'b1;
          end else begin
            // Line full: move to the next row and blank it before use
            w_col_nxt   = '0;
            w_row_nxt   = w_row_inc;
            w_sweep_nxt = '0;
            w_state_nxt = S_CLR_ROW;
          end
        end
      end
    endcase
  end

  // Array write port and handshake outputs
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = BLANK_ID;
    case (r_state)
      S_CLR_ALL: begin
        w_we    = 1'b1;
        w_waddr = r_sweep;
      end
      S_CLR_ROW: begin
        w_we    = 1'b1;
        w_waddr = f_addr(r_row, COL_W'(r_sweep));
      end
      default: begin
        if (w_fire) begin
          if (in_char == CH_BS) begin
            // Blank the cell the cursor moves back onto; no write at (0,0)
            w_we    = (r_col != '0) || (r_row != '0);
            w_waddr = f_addr(w_row_nxt, w_col_nxt);
          end else if (in_char != CH_NL && in_char != CH_FF) begin
            w_we    = 1'b1;
            w_waddr = f_addr(r_row, r_col);
            w_wdata = in_char;
          end
        end
      end
    endcase
    if (!rst_n) w_we = 1'b0;
    in_ready = (r_state == S_IDLE);
    busy     = (r_state != S_IDLE);
  end

  // Character array write; contents are not reset, the sweep initialises them
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  assign w_rd_addr    = f_addr(char_row, char_col);
  assign character_id = (int'(char_row) < ROWS && int'(char_col) < COLS) ?
                        r_mem[w_rd_addr] : BLANK_ID;
  assign cursor_row   = r_row;
  assign cursor_col   = r_col;

endmodule
